// File: rtl/io_port_decoder_if.sv
// ============================================================================
// Module      : io_port_decoder_if
// Description : Data-bus I/O access channel between bus master and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface io_port_decoder_if;
    logic        data_m_access;
    logic [15:1] data_m_addr;
    logic        data_m_wr_en;
    logic        data_m_ack;
    logic [15:0] data_m_data_in;

    modport master (
        output data_m_access,
        output data_m_addr,
        output data_m_wr_en,
        input  data_m_ack,
        input  data_m_data_in
    );

    modport slave (
        input  data_m_access,
        input  data_m_addr,
        input  data_m_wr_en,
        output data_m_ack,
        output data_m_data_in
    );
endinterface

`default_nettype wire

// File: rtl/io_port_decoder.sv
// ============================================================================
// Module      : io_port_decoder
// Description : Base/mask I/O window decoder with one-hot select, response
//               collection, unmapped-port answer and access timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_port_decoder #(
    parameter int                        NUM_SLAVES     = 8,
    parameter logic [16*NUM_SLAVES-1:0]  SLAVE_BASE     = '0,
    parameter logic [16*NUM_SLAVES-1:0]  SLAVE_MASK     = '0,
    parameter int                        TIMEOUT_CYCLES = 255,
    parameter logic [15:0]               TIMEOUT_DATA   = 16'hffff,
    parameter logic [15:0]               UNMAPPED_DATA  = 16'h0000
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    io_port_decoder_if.slave              bus,
    output logic [NUM_SLAVES-1:0]         cs,
    input  wire logic [NUM_SLAVES-1:0]    slave_ack,
    input  wire logic [16*NUM_SLAVES-1:0] slave_data,
    output logic                          timeout_err,
    output logic [15:0]                   err_addr,
    input  wire logic                     err_clr
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACTIVE   = 2'd1,
        S_UNMAPPED = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    localparam logic [15:0] c_TIMEOUT_CNT = 16'(TIMEOUT_CYCLES);

    state_t                  r_state;
    logic                    r_prev_resp;
    logic [NUM_SLAVES-1:0]   r_cs;
    logic [15:1]             r_addr;
    logic [15:0]             r_cnt;
    logic                    r_ack;
    logic [15:0]             r_rdata;
    logic                    r_timeout_err;
    logic [15:0]             r_err_addr;

    logic [15:0]             w_addr;
    logic [NUM_SLAVES-1:0]   w_dec;
    logic                    w_sel_ack;
    logic [15:0]             w_sel_data;
    logic                    w_timeout;
    logic                    w_to_fire;
    logic                    w_unused_wr_en;

    assign w_unused_wr_en = bus.data_m_wr_en;
    assign w_addr         = {bus.data_m_addr, 1'b0};

    // Descending scan so the lowest matching slot overwrites any higher one.
    always_comb begin
        w_dec = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((w_addr & SLAVE_MASK[16*i +: 16]) ==
                (SLAVE_BASE[16*i +: 16] & SLAVE_MASK[16*i +: 16])) begin
                w_dec    = '0;
                w_dec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_cs[i]) begin
                w_sel_data = w_sel_data | slave_data[16*i +: 16];
            end
        end
    end

    assign w_sel_ack = |(slave_ack & r_cs);
    // r_cnt equals TIMEOUT_CYCLES on the cycle after the full wait window.
    assign w_timeout = (r_cnt == c_TIMEOUT_CNT);
    assign w_to_fire = (r_state == S_ACTIVE) && bus.data_m_access &&
                       !w_sel_ack && w_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_prev_resp   <= 1'b0;
            r_cs          <= '0;
            r_addr        <= '0;
            r_cnt         <= '0;
            r_ack         <= 1'b0;
            r_rdata       <= '0;
            r_timeout_err <= 1'b0;
            r_err_addr    <= '0;
        end else begin
            r_ack       <= 1'b0;
            r_prev_resp <= (r_state == S_RESP);
            case (r_state)
                S_IDLE: begin
                    // The access still held in the cycle after ack is not a new request.
                    if (bus.data_m_access && !r_prev_resp) begin
                        r_addr <= bus.data_m_addr;
                        r_cnt  <= '0;
                        if (|w_dec) begin
                            r_cs    <= w_dec;
                            r_state <= S_ACTIVE;
                        end else begin
                            r_state <= S_UNMAPPED;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (!bus.data_m_access) begin
                        r_cs    <= '0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_sel_ack) begin
                        r_rdata <= w_sel_data;
                        r_cs    <= '0;
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_rdata <= TIMEOUT_DATA;
                        r_cs    <= '0;
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_UNMAPPED: begin
                    if (!bus.data_m_access) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rdata <= UNMAPPED_DATA;
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cs    <= '0;
                    r_state <= S_IDLE;
                end
            endcase

            if (err_clr) begin
                r_timeout_err <= 1'b0;
                r_err_addr    <= '0;
            end else if (w_to_fire) begin
                r_timeout_err <= 1'b1;
                if (!r_timeout_err) begin
                    r_err_addr <= {r_addr, 1'b0};
                end
            end
        end
    end

    assign cs                 = r_cs;
    assign bus.data_m_ack     = r_ack;
    assign bus.data_m_data_in = r_rdata;
    assign timeout_err        = r_timeout_err;
    assign err_addr           = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_io_port_decoder.sv
// ============================================================================
// Module      : tb_io_port_decoder
// Description : Self-checking bench for io_port_decoder (vector table plus
//               directed timeout/abort/reset sequences, scoreboarded acks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_port_decoder;

    localparam int NS = 8;
    localparam logic [16*NS-1:0] c_BASE = {16'h800e, 16'h800c, 16'h800a, 16'h8008,
                                           16'h8006, 16'h0040, 16'h0040, 16'hfffe};
    localparam logic [16*NS-1:0] c_MASK = {16'hffff, 16'hffff, 16'hffff, 16'hffff,
                                           16'hffff, 16'hfff0, 16'hfffc, 16'hfffe};

    logic             clk;
    logic             reset_n;
    logic [NS-1:0]    cs;
    logic [NS-1:0]    slave_ack;
    logic [16*NS-1:0] slave_data;
    logic             timeout_err;
    logic [15:0]      err_addr;
    logic             err_clr;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int slv_delay [NS];
    int scnt      [NS];

    typedef struct {
        logic [15:0] data;
        int          lat;
        int          t0;
    } sb_t;
    sb_t sb_q [$];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  exp_cs;
        int          exp_lat;
        logic [15:0] exp_data;
    } vec_t;
    vec_t vecs [8];

    io_port_decoder_if bus ();

    io_port_decoder #(
        .NUM_SLAVES     (NS),
        .SLAVE_BASE     (c_BASE),
        .SLAVE_MASK     (c_MASK),
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_DATA   (16'hffff),
        .UNMAPPED_DATA  (16'h0000)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .cs          (cs),
        .slave_ack   (slave_ack),
        .slave_data  (slave_data),
        .timeout_err (timeout_err),
        .err_addr    (err_addr),
        .err_clr     (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Slave i acks for one cycle, slv_delay[i] cycles after its cs rises (0 = never).
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (cs[i]) begin
                slave_ack[i] <= (slv_delay[i] != 0) && (scnt[i] == slv_delay[i] - 1);
                scnt[i]      <= scnt[i] + 1;
            end else begin
                slave_ack[i] <= 1'b0;
                scnt[i]      <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_access(input logic [15:0] addr, input logic [7:0] exp_cs,
                              input int exp_lat, input logic [15:0] exp_data, input int hold);
        sb_t r;
        sb_t dummy;
        bit  got;
        @(posedge clk); #1;
        bus.data_m_access = 1'b1;
        bus.data_m_addr   = addr[15:1];
        r.data = exp_data;
        r.lat  = exp_lat;
        r.t0   = cyc;
        sb_q.push_back(r);
        @(negedge clk);
        @(negedge clk);
        chk("cs_decode", 32'(cs), 32'(exp_cs));
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (bus.data_m_ack) got = 1'b1;
            else @(negedge clk);
        end
        chk("ack_seen", 32'(got), 32'd1);
        if (!got && sb_q.size() > 0) dummy = sb_q.pop_back();
        for (int k = 0; k < hold; k++) @(posedge clk);
        @(posedge clk); #1;
        bus.data_m_access = 1'b0;
    endtask

    initial begin
        logic any_cs;
        reset_n           = 1'b0;
        err_clr           = 1'b0;
        bus.data_m_access = 1'b0;
        bus.data_m_addr   = '0;
        bus.data_m_wr_en  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            slv_delay[i] = 1;
            scnt[i]      = 0;
            slave_data[16*i +: 16] = (i == 0) ? 16'h1234 : (16'ha000 + 16'(i));
        end
        slave_ack    = '0;
        slv_delay[1] = 2;
        slv_delay[2] = 3;

        vecs[0] = '{16'hfffe, 8'b0000_0001, 3, 16'h1234};
        vecs[1] = '{16'h0042, 8'b0000_0010, 4, 16'ha001};
        vecs[2] = '{16'h0048, 8'b0000_0100, 5, 16'ha002};
        vecs[3] = '{16'h0300, 8'b0000_0000, 2, 16'h0000};
        vecs[4] = '{16'h0040, 8'b0000_0010, 4, 16'ha001};
        vecs[5] = '{16'h8006, 8'b0000_1000, 3, 16'ha003};
        vecs[6] = '{16'h800e, 8'b1000_0000, 3, 16'ha007};
        vecs[7] = '{16'h004e, 8'b0000_0100, 5, 16'ha002};

        fork
            forever begin
                sb_t r;
                @(negedge clk);
                if (reset_n && bus.data_m_ack) begin
                    chk("sb_pending", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) begin
                        r = sb_q.pop_front();
                        chk("rdata", 32'(bus.data_m_data_in), 32'(r.data));
                        chk("ack_latency", 32'(cyc - r.t0), 32'(r.lat));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_cs", 32'(cs), 32'd0);
        chk("rst_ack", 32'(bus.data_m_ack), 32'd0);
        chk("rst_rdata", 32'(bus.data_m_data_in), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i].addr, vecs[i].exp_cs, vecs[i].exp_lat, vecs[i].exp_data, 0);
            chk("rdata_hold", 32'(bus.data_m_data_in), 32'(vecs[i].exp_data));
            chk("no_err", 32'(timeout_err), 32'd0);
        end

        // Timeout with sticky first-address capture, then clear.
        slv_delay[1] = 0;
        run_access(16'h0040, 8'b0000_0010, 6, 16'hffff, 0);
        chk("to_err_set", 32'(timeout_err), 32'd1);
        chk("to_err_addr", 32'(err_addr), 32'h0040);
        run_access(16'h0042, 8'b0000_0010, 6, 16'hffff, 0);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        chk("to_err_addr_first", 32'(err_addr), 32'h0040);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        chk("clr_err", 32'(timeout_err), 32'd0);
        chk("clr_err_addr", 32'(err_addr), 32'd0);

        // Ack landing on the timeout decision cycle wins.
        slv_delay[1] = 4;
        run_access(16'h0040, 8'b0000_0010, 6, 16'ha001, 0);
        chk("edge_ack_no_err", 32'(timeout_err), 32'd0);

        // Access held one cycle past ack must not restart.
        run_access(16'hfffe, 8'b0000_0001, 3, 16'h1234, 1);
        any_cs = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_cs = any_cs | (|cs);
        end
        chk("held_no_restart", 32'(any_cs), 32'd0);

        // Abort in ACTIVE.
        slv_delay[1] = 0;
        @(posedge clk); #1;
        bus.data_m_access = 1'b1;
        bus.data_m_addr   = 15'h0020;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_cs_up", 32'(cs), 32'h02);
        @(posedge clk); #1 bus.data_m_access = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_cs_drop", 32'(cs), 32'd0);
        repeat (8) @(negedge clk);
        chk("abort_no_err", 32'(timeout_err), 32'd0);

        // Asynchronous reset in ACTIVE.
        @(posedge clk); #1;
        bus.data_m_access = 1'b1;
        bus.data_m_addr   = 15'h0020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_cs", 32'(cs), 32'h02);
        reset_n = 1'b0;
        #1;
        chk("arst_cs", 32'(cs), 32'd0);
        chk("arst_ack", 32'(bus.data_m_ack), 32'd0);
        chk("arst_rdata", 32'(bus.data_m_data_in), 32'd0);
        bus.data_m_access = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        slv_delay[1] = 2;
        run_access(16'hfffe, 8'b0000_0001, 3, 16'h1234, 0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
